// File: rtl/forwarding_pkg.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_pkg
// Description : Shared types and helpers for the forwarding scoreboard.
//               Scoreboard entry (busy, tag) and writeback bus (valid, rd,
//               tag, data) structs, plus width-derivation functions.
//               Struct fields are sized for the largest supported geometry
//               (REG_W <= 8, TAG_W <= 8, VLEN <= 256); narrower
//               configurations zero-extend into them.
// Revision    : 1.0 - initial release
// ============================================================================
package forwarding_pkg;

    localparam int REG_W_MAX = 8;
    localparam int TAG_W_MAX = 8;
    localparam int VLEN_MAX  = 256;

    // Register-index width for a file of nregs entries.
    function automatic int reg_w_of(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Tag width needed to keep max_inflight writers distinct
    // (one code point is always left free).
    function automatic int tag_w_of(input int max_inflight);
        return (max_inflight > 1) ? $clog2(max_inflight + 1) : 1;
    endfunction

    typedef struct packed {
        logic                 busy;
        logic [TAG_W_MAX-1:0] tag;
    } sb_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [REG_W_MAX-1:0] rd;
        logic [TAG_W_MAX-1:0] tag;
        logic [VLEN_MAX-1:0]  data;
    } wb_bus_t;

endpackage
`default_nettype wire

// File: rtl/fwd_operand_select.sv
`default_nettype none
// ============================================================================
// Module      : fwd_operand_select
// Description : Per-operand hazard resolution. Picks the lowest-numbered
//               matching writeback bus for a busy source, consults the hold
//               latch for a just-retired source, and flags an unresolved
//               hazard otherwise.
//               Optional feature macro: FWD_HOLD_STAGE_EN (forward from the
//               hold latch instead of stalling one cycle).
// Ports       : src_valid/src_addr - operand read request
//               src_busy           - scoreboard busy bit of src_addr
//               wb_rd/wb_data/wb_hit - writeback buses and their tag matches
//               hold_valid/hold_rd(/hold_data) - previous-cycle matches
//               fwd_sel/fwd_data   - forwarding mux result
//               hazard             - operand cannot be resolved this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_operand_select
    import forwarding_pkg::*;
#(
    parameter int VLEN  = 256,
    parameter int NWB   = 2,
    parameter int REG_W = 5
) (
    input  logic                  src_valid,
    input  logic [REG_W-1:0]      src_addr,
    input  logic                  src_busy,
    input  logic [NWB*REG_W-1:0]  wb_rd,
    input  logic [NWB*VLEN-1:0]   wb_data,
    input  logic [NWB-1:0]        wb_hit,
    input  logic [NWB-1:0]        hold_valid,
    input  logic [NWB*REG_W-1:0]  hold_rd,
`ifdef FWD_HOLD_STAGE_EN
    input  logic [NWB*VLEN-1:0]   hold_data,
`endif
    output logic                  fwd_sel,
    output logic [VLEN-1:0]       fwd_data,
    output logic                  hazard
);

    logic w_active;

    assign w_active = src_valid && (src_addr != '0);

    // Buses are scanned from highest to lowest so the lowest index is the
    // last assignment and therefore wins.
    always_comb begin
        fwd_sel  = 1'b0;
        fwd_data = '0;
        hazard   = 1'b0;
        if (w_active) begin
            if (src_busy) begin
                hazard = 1'b1;
                for (int k = NWB - 1; k >= 0; k--) begin
                    if (wb_hit[k] && (wb_rd[k*REG_W +: REG_W] == src_addr)) begin
                        fwd_sel  = 1'b1;
                        fwd_data = wb_data[k*VLEN +: VLEN];
                        hazard   = 1'b0;
                    end
                end
            end else begin
                // Result retired last edge; the register file write is not
                // visible until the next cycle.
                for (int k = NWB - 1; k >= 0; k--) begin
                    if (hold_valid[k] && (hold_rd[k*REG_W +: REG_W] == src_addr)) begin
`ifdef FWD_HOLD_STAGE_EN
                        fwd_sel  = 1'b1;
                        fwd_data = hold_data[k*VLEN +: VLEN];
`else
                        hazard   = 1'b1;
`endif
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/forwarding_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_scoreboard
// Description : RAW-hazard scoreboard and operand forwarding unit. Tracks one
//               in-flight writer per register (busy + issue tag), matches
//               tagged writeback buses, forwards VLEN-wide results and stalls
//               issue on unresolved hazards. Tolerates out-of-order and
//               variable-latency writeback.
//               Optional feature macro: FWD_HOLD_STAGE_EN.
// Ports       : clk, rst_n (async active-low)
//               issue_valid/issue_we/issue_rd - issuing instruction
//               src_valid/src_addr             - its source operands
//               wb_valid/wb_rd/wb_tag/wb_data  - writeback buses
//               flush                          - drop all in-flight writers
//               issue_tag, stall, fwd_sel, fwd_data, busy_vec - results
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_scoreboard
    import forwarding_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int VLEN  = 256,
    parameter int NSRC  = 2,
    parameter int NWB   = 2,
    parameter int TAG_W = 3,
    localparam int REG_W = reg_w_of(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic [REG_W-1:0]      issue_rd,
    input  logic [NSRC-1:0]       src_valid,
    input  logic [NSRC*REG_W-1:0] src_addr,
    input  logic [NWB-1:0]        wb_valid,
    input  logic [NWB*REG_W-1:0]  wb_rd,
    input  logic [NWB*TAG_W-1:0]  wb_tag,
    input  logic [NWB*VLEN-1:0]   wb_data,
    input  logic                  flush,
    output logic [TAG_W-1:0]      issue_tag,
    output logic                  stall,
    output logic [NSRC-1:0]       fwd_sel,
    output logic [NSRC*VLEN-1:0]  fwd_data,
    output logic [NREGS-1:0]      busy_vec
);

    sb_entry_t               r_sb [NREGS];
    logic [TAG_W-1:0]        r_tag_cnt;
    logic [NWB-1:0]          r_hold_valid;
    logic [NWB*REG_W-1:0]    r_hold_rd;
`ifdef FWD_HOLD_STAGE_EN
    logic [NWB*VLEN-1:0]     r_hold_data;
`endif

    wb_bus_t [NWB-1:0]       w_wb;
    logic [NWB*VLEN-1:0]     w_bus_data;
    logic [NWB-1:0]          w_wb_hit;
    logic [NWB-1:0]          w_hold_cap;
    logic [NREGS-1:0]        w_wb_clear;
    logic [NSRC-1:0]         w_src_busy;
    logic [NSRC-1:0]         w_hazard;
    logic                    w_accept;

    assign issue_tag = r_tag_cnt;
    assign stall     = issue_valid && (|w_hazard);
    assign w_accept  = issue_valid && !stall && !flush;

    generate
        for (genvar k = 0; k < NWB; k++) begin : g_wb
            assign w_wb[k].valid = wb_valid[k];
            assign w_wb[k].rd    = REG_W_MAX'(wb_rd[k*REG_W +: REG_W]);
            assign w_wb[k].tag   = TAG_W_MAX'(wb_tag[k*TAG_W +: TAG_W]);
            assign w_wb[k].data  = VLEN_MAX'(wb_data[k*VLEN +: VLEN]);
            assign w_bus_data[k*VLEN +: VLEN] = w_wb[k].data[VLEN-1:0];
        end
    endgenerate

    // A writeback only counts if it belongs to the youngest writer of its
    // register; stale tags (older WAW writers, post-flush stragglers) drop.
    always_comb begin
        logic [REG_W-1:0] v_rd;
        w_wb_hit   = '0;
        w_wb_clear = '0;
        for (int k = 0; k < NWB; k++) begin
            v_rd = wb_rd[k*REG_W +: REG_W];
            if (w_wb[k].valid && (w_wb[k].rd != '0) && r_sb[v_rd].busy &&
                (r_sb[v_rd].tag == w_wb[k].tag)) begin
                w_wb_hit[k]      = 1'b1;
                w_wb_clear[v_rd] = 1'b1;
            end
        end
    end

    // Only the lowest bus matching a given rd is kept in the hold latch.
    always_comb begin
        w_hold_cap = w_wb_hit;
        for (int k = 1; k < NWB; k++) begin
            for (int j = 0; j < k; j++) begin
                if (w_wb_hit[j] && (wb_rd[j*REG_W +: REG_W] == wb_rd[k*REG_W +: REG_W])) begin
                    w_hold_cap[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        busy_vec = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy_vec[r] = r_sb[r].busy;
        end
    end

    // Clears are applied before the issue write so a same-edge issue to the
    // retiring register keeps it busy under the new tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_sb[r] <= '0;
            end
            r_tag_cnt    <= '0;
            r_hold_valid <= '0;
            r_hold_rd    <= '0;
`ifdef FWD_HOLD_STAGE_EN
            r_hold_data  <= '0;
`endif
        end else if (flush) begin
            for (int r = 0; r < NREGS; r++) begin
                r_sb[r].busy <= 1'b0;
            end
            r_hold_valid <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (w_wb_clear[r]) begin
                    r_sb[r].busy <= 1'b0;
                end
            end
            if (w_accept && issue_we && (issue_rd != '0)) begin
                r_sb[issue_rd].busy <= 1'b1;
                r_sb[issue_rd].tag  <= TAG_W_MAX'(r_tag_cnt);
                r_tag_cnt           <= r_tag_cnt + 1'b1;
            end
            r_hold_valid <= w_hold_cap;
            r_hold_rd    <= wb_rd;
`ifdef FWD_HOLD_STAGE_EN
            r_hold_data  <= wb_data;
`endif
        end
    end

    generate
        for (genvar i = 0; i < NSRC; i++) begin : g_src
            assign w_src_busy[i] = r_sb[src_addr[i*REG_W +: REG_W]].busy;

            fwd_operand_select #(
                .VLEN  (VLEN),
                .NWB   (NWB),
                .REG_W (REG_W)
            ) u_sel (
                .src_valid  (src_valid[i]),
                .src_addr   (src_addr[i*REG_W +: REG_W]),
                .src_busy   (w_src_busy[i]),
                .wb_rd      (wb_rd),
                .wb_data    (w_bus_data),
                .wb_hit     (w_wb_hit),
                .hold_valid (r_hold_valid),
                .hold_rd    (r_hold_rd),
`ifdef FWD_HOLD_STAGE_EN
                .hold_data  (r_hold_data),
`endif
                .fwd_sel    (fwd_sel[i]),
                .fwd_data   (fwd_data[i*VLEN +: VLEN]),
                .hazard     (w_hazard[i])
            );
        end
    endgenerate

endmodule
`default_nettype wire
